block_ram_dp: RTL and testbench
===============================

BLOCK_RAM_DP -- requirements
Module: block_ram_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width; legal values are multiples of 8, from 8 to 128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, word address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter READ_MODE, default 0; 0 = read-first, 1 = write-first (same-port read during write).
REQ-004 SHALL have parameter OUT_REG, default 0; 1 adds one output pipeline register per port.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clka input 1, the single clock for both ports; rsta input 1, asynchronous active-high reset.
REQ-006 SHALL have port A ports: ena input 1 port enable; addra input ADDR_WIDTH word address; dina input DATA_WIDTH write data; wea input DATA_WIDTH/8 byte-lane write enables; douta output DATA_WIDTH read data.
REQ-007 SHALL have port B ports: enb, addrb, dinb, web and doutb, identical in width and meaning to port A.
REQ-008 SHALL have control ports: clr input 1 (clear request, sampled at the clock edge); busy output 1 (clear in progress); clr_done output 1 (one-cycle pulse when a clear completes).

Function
REQ-009 Port write: with enX=1 and weX[i]=1, byte lane i of mem[addrX] SHALL take dinX[8i+7:8i] at the clock edge; lanes with weX[i]=0 are unchanged.
REQ-010 Port read: with enX=1, doutX SHALL present mem[addrX] 1+OUT_REG cycles after the request edge; with enX=0, doutX and its pipeline SHALL hold their values.
REQ-011 Same-port read during write: READ_MODE=0 returns the pre-write word; READ_MODE=1 returns the merged word (new bytes on written lanes, old bytes elsewhere).
REQ-012 Cross-port read of an address the other port writes in the same cycle SHALL return the pre-write word, regardless of READ_MODE.
REQ-013 If both ports write the same address in the same cycle, port A SHALL win on each lane both enable; lanes only one port enables take that port's data.
REQ-014 Clear FSM states: IDLE and CLEAR.
REQ-015 IDLE to CLEAR on clr=1; the address counter starts at 0 and busy rises in the next cycle.
REQ-016 CLEAR writes all-zero data to mem[cnt] each cycle, cnt+1; after cnt = DEPTH-1 the FSM returns to IDLE, busy falls and clr_done pulses for one cycle. A clear takes exactly DEPTH cycles.
REQ-017 While busy=1, all port writes SHALL be dropped, port reads SHALL be ignored and doutX SHALL hold.
REQ-018 A clr asserted during CLEAR SHALL be ignored, with no restart.
REQ-019 A clr in the same cycle as a port access SHALL let that access complete normally; the clear starts on the following edge.
REQ-020 The address counter SHALL be ADDR_WIDTH+1 bits so termination needs no wrap-around compare.

Reset
REQ-021 rsta=1 SHALL force: douta, doutb and the pipeline registers to 0; busy=0; clr_done=0; FSM to IDLE; counter to 0.
REQ-022 Reset SHALL NOT initialise memory contents. Contents are undefined at power-up; an optional hex file path parameter INIT_FILE, default empty, loads the array at elaboration.
REQ-023 Reset during CLEAR SHALL abort the clear immediately, with no clr_done; the already-zeroed words stay zero and the rest keep their old contents.
REQ-024 The memory array SHALL have no reset path, so it maps to block RAM.

Structure
REQ-025 The shared package SHALL hold the READ_MODE encodings (RM_READ_FIRST=0, RM_WRITE_FIRST=1) and the FSM state encodings (ST_IDLE, ST_CLEAR).
REQ-026 One sub-module, bram_out_pipe, SHALL implement the per-port output stage (OUT_REG bypass or register, hold on enable, async reset) and be instantiated twice.
REQ-027 The array SHALL carry the block-RAM style attribute; the clear engine SHALL share port A's write path through a mux.

Verification
REQ-028 Byte lanes: A writes 0x11223344 to addr 5 with wea=1111, then 0xAABBCCDD with wea=0101; a read of addr 5 returns 0x11BB33DD after 1+OUT_REG cycles.
REQ-029 Read during write: with READ_MODE=0, old=0x0, A writes 0xDEADBEEF to addr 7 while reading it: douta=0x0, and the next read gives 0xDEADBEEF; READ_MODE=1 gives 0xDEADBEEF at once.
REQ-030 Collision: the same cycle, addr 3, A writes 0x000000AA with wea=0001 and B writes 0xBBBBBBBB with web=1111; the result is 0xBBBBBBAA; B reading addr 3 while A writes returns the old value.
REQ-031 Clear: with ADDR_WIDTH=4, preload all 16 words with 0xFF, then pulse clr: busy is high for exactly 16 cycles, clr_done pulses once, every word reads 0, and a write during busy is dropped.
REQ-032 Reset mid-clear: with ADDR_WIDTH=4, assert rsta after 6 clear cycles: busy=0 immediately, no clr_done, addr 0-5 read 0 and addr 6-15 read 0xFF.
REQ-033 Enable hold: with enb=0 over 3 cycles while addrb changes, doutb stays constant; with OUT_REG=1, latency is 2 cycles.

Source files
------------

// File: rtl/block_ram_dp_pkg.sv
// Shared definitions for the dual-port block RAM: read-mode encodings and the
// states of the clear engine.
package block_ram_dp_pkg;

  // Same-port read-during-write behaviour.
  localparam int RM_READ_FIRST  = 0;
  localparam int RM_WRITE_FIRST = 1;

  // Clear engine states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/block_ram_dp_out_pipe.sv
// Per-port output stage of the dual-port RAM. With OUT_REG=0 the RAM read
// register drives the port directly. With OUT_REG=1 one extra register is added.
// That register loads only when a read landed in the RAM read register on the
// previous edge, so an idle port keeps its last output.
module bram_out_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] q_reg;

  // Optional output register: loads on a completed read, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (en) begin
      // NOTE: sequential state is always assigned with <= so every register
      // samples the values from before the edge, independent of block order.
      q_reg <= d;
    end
  end

  // With OUT_REG=0 the register above has no load and is removed in synthesis.
  assign q = (OUT_REG != 0) ? q_reg : d;

endmodule

// File: rtl/block_ram_dp.sv
// True dual-port block RAM on a single clock, with byte-lane write enables.
// READ_MODE selects read-first or write-first behaviour for a port that reads
// the address it is writing. OUT_REG adds an optional output register.
// The clear engine zeroes the whole array one word per cycle. It takes over
// port A's write path while it runs.
module block_ram_dp
  import block_ram_dp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int READ_MODE  = 0,
  parameter int OUT_REG    = 0,
  parameter     INIT_FILE  = ""
) (
  input  logic                    clka,
  input  logic                    rsta,
  // port A
  input  logic                    ena,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  input  logic [DATA_WIDTH/8-1:0] wea,
  output logic [DATA_WIDTH-1:0]   douta,
  // port B
  input  logic                    enb,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   dinb,
  input  logic [DATA_WIDTH/8-1:0] web,
  output logic [DATA_WIDTH-1:0]   doutb,
  // clear control
  input  logic                    clr,
  output logic                    busy,
  output logic                    clr_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  // Clear engine. The counter has one extra bit; its carry into that bit marks
  // the last word, so no compare against DEPTH-1 is needed.
  clr_state_t            state, state_nxt;
  logic [ADDR_WIDTH:0]   cnt, cnt_nxt, cnt_inc;
  logic                  clr_done_nxt;

  // Clear FSM next-state and counter logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_nxt    = state;
    cnt_nxt      = cnt;
    clr_done_nxt = 1'b0;
    cnt_inc      = cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
    case (state)
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // A clr seen here is ignored; the running clear is never restarted.
        if (cnt_inc[ADDR_WIDTH]) begin
          state_nxt    = ST_IDLE;
          cnt_nxt      = '0;
          clr_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Clear FSM state register. Reset aborts a clear without a done pulse.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_done <= clr_done_nxt;
    end
  end

  assign busy = (state == ST_CLEAR);

  // Write path. While busy, the clear engine owns port A's write path and
  // port B's writes are dropped.
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0] wa_data;
  logic [NB-1:0]         wa_we, wb_we;
  logic                  rd_en_a, rd_en_b;

  // Port A write mux (clear engine or user) and port B write gating.
  always_comb begin
    wa_addr = addra;
    wa_data = dina;
    wa_we   = ena ? wea : '0;
    wb_we   = (enb && !busy) ? web : '0;
    if (busy) begin
      wa_addr = cnt[ADDR_WIDTH-1:0];
      wa_data = '0;
      wa_we   = '1;
    end
  end

  assign rd_en_a = ena && !busy;
  assign rd_en_b = enb && !busy;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array writes. B's lanes are written first and A's second, so on a lane
  // that both ports enable at the same address, A's data is the one kept.
  always_ff @(posedge clka) begin
    // NOTE: the array has no reset branch. A reset would stop it mapping to
    // block RAM, and reset is not meant to change the stored words.
    for (int i = 0; i < NB; i++) begin
      if (wb_we[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
      if (wa_we[i]) mem[wa_addr][8*i +: 8] <= wa_data[8*i +: 8];
    end
  end

  // Write-first view of each port's word: its own new bytes over the old word.
  logic [DATA_WIDTH-1:0] merged_a, merged_b;

  // Merge each port's write data into its addressed word, per byte lane.
  always_comb begin
    merged_a = mem[addra];
    merged_b = mem[addrb];
    for (int i = 0; i < NB; i++) begin
      if (wea[i]) merged_a[8*i +: 8] = dina[8*i +: 8];
      if (web[i]) merged_b[8*i +: 8] = dinb[8*i +: 8];
    end
  end

  // RAM read registers. The array value read here is the pre-write word, so
  // a read of an address the other port is writing returns the old data.
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic                  rd_vld_a, rd_vld_b;

  // RAM read registers; they hold while the port is disabled or busy.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      rd_a     <= '0;
      rd_b     <= '0;
      rd_vld_a <= 1'b0;
      rd_vld_b <= 1'b0;
    end else begin
      rd_vld_a <= rd_en_a;
      rd_vld_b <= rd_en_b;
      if (rd_en_a) rd_a <= (READ_MODE == RM_WRITE_FIRST) ? merged_a : mem[addra];
      if (rd_en_b) rd_b <= (READ_MODE == RM_WRITE_FIRST) ? merged_b : mem[addrb];
    end
  end

  bram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk (clka),
    .rst (rsta),
    .en  (rd_vld_a),
    .d   (rd_a),
    .q   (douta)
  );

  bram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk (clka),
    .rst (rsta),
    .en  (rd_vld_b),
    .d   (rd_b),
    .q   (doutb)
  );

endmodule

// File: tb/tb_block_ram_dp.sv
// Bench for block_ram_dp. Two instances share one set of inputs:
// dut0 is read-first with no output register, and dut1 is write-first with
// the output register. A bench model of the memory and the clear engine
// predicts every read. Expected reads are queued with their due cycle, then
// compared at the falling edge of that cycle.
module tb_block_ram_dp;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rsta;
  logic          ena, enb, clr;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;
  logic [3:0]    wea, web;
  logic [DW-1:0] douta0, doutb0, douta1, doutb1;
  logic          busy0, busy1, done0, done1;

  block_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(0), .OUT_REG(0)) dut0 (
    .clka(clk), .rsta(rsta),
    .ena(ena), .addra(addra), .dina(dina), .wea(wea), .douta(douta0),
    .enb(enb), .addrb(addrb), .dinb(dinb), .web(web), .doutb(doutb0),
    .clr(clr), .busy(busy0), .clr_done(done0)
  );

  block_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_MODE(1), .OUT_REG(1)) dut1 (
    .clka(clk), .rsta(rsta),
    .ena(ena), .addra(addra), .dina(dina), .wea(wea), .douta(douta1),
    .enb(enb), .addrb(addrb), .dinb(dinb), .web(web), .doutb(doutb1),
    .clr(clr), .busy(busy1), .clr_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
  } exp_t;

  exp_t        qa0[$], qb0[$], qa1[$], qb1[$];
  logic [31:0] model [DEPTH];
  logic        m_busy, m_done;
  int          m_cnt;
  int          edge_n;
  int          vectors, miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One clock cycle: drive inputs, predict the edge in the model, take the
  // edge, then check busy/clr_done.
  task automatic step(input logic a_en, input logic [AW-1:0] a_ad, input logic [31:0] a_d,
                      input logic [3:0] a_w, input logic b_en, input logic [AW-1:0] b_ad,
                      input logic [31:0] b_d, input logic [3:0] b_w, input logic c);
    ena = a_en; addra = a_ad; dina = a_d; wea = a_w;
    enb = b_en; addrb = b_ad; dinb = b_d; web = b_w;
    clr = c;
    if (m_busy) begin
      model[m_cnt] = '0;
      m_cnt++;
      m_done = (m_cnt == DEPTH);
      if (m_cnt == DEPTH) m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (a_en) begin
        qa0.push_back('{due: edge_n + 1, data: model[a_ad]});
        qa1.push_back('{due: edge_n + 2, data: merge(model[a_ad], a_d, a_w)});
      end
      if (b_en) begin
        qb0.push_back('{due: edge_n + 1, data: model[b_ad]});
        qb1.push_back('{due: edge_n + 2, data: merge(model[b_ad], b_d, b_w)});
      end
      if (b_en) model[b_ad] = merge(model[b_ad], b_d, b_w);
      if (a_en) model[a_ad] = merge(model[a_ad], a_d, a_w);
      if (c) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    edge_n++;
    #1;
    check($sformatf("busy0@%0d", edge_n), {31'b0, busy0}, {31'b0, m_busy});
    check($sformatf("busy1@%0d", edge_n), {31'b0, busy1}, {31'b0, m_busy});
    check($sformatf("done0@%0d", edge_n), {31'b0, done0}, {31'b0, m_done});
    check($sformatf("done1@%0d", edge_n), {31'b0, done1}, {31'b0, m_done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_a(input logic [AW-1:0] ad, input logic [31:0] d, input logic [3:0] we);
    step(1, ad, d, we, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_ab(input logic [AW-1:0] aa, input logic [AW-1:0] ba);
    step(1, aa, 0, 0, 1, ba, 0, 0, 0);
  endtask

  // Scoreboard: compare each queued read in the cycle it is due.
  always @(negedge clk) begin
    exp_t e;
    if (qa0.size() != 0 && qa0[0].due == edge_n) begin
      e = qa0.pop_front();
      check($sformatf("douta0@%0d", edge_n), douta0, e.data);
    end
    if (qb0.size() != 0 && qb0[0].due == edge_n) begin
      e = qb0.pop_front();
      check($sformatf("doutb0@%0d", edge_n), doutb0, e.data);
    end
    if (qa1.size() != 0 && qa1[0].due == edge_n) begin
      e = qa1.pop_front();
      check($sformatf("douta1@%0d", edge_n), douta1, e.data);
    end
    if (qb1.size() != 0 && qb1[0].due == edge_n) begin
      e = qb1.pop_front();
      check($sformatf("doutb1@%0d", edge_n), doutb1, e.data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0; edge_n = 0;
    m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    rsta = 1'b0;
    ena = 0; enb = 0; clr = 0; addra = 0; addrb = 0; dina = 0; dinb = 0; wea = 0; web = 0;

    // Reset state
    #2 rsta = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_douta0", douta0, 32'h0);
    check("rst_doutb0", doutb0, 32'h0);
    check("rst_douta1", douta1, 32'h0);
    check("rst_doutb1", doutb1, 32'h0);
    check("rst_busy0", {31'b0, busy0}, 32'h0);
    check("rst_busy1", {31'b0, busy1}, 32'h0);
    check("rst_done0", {31'b0, done0}, 32'h0);
    check("rst_done1", {31'b0, done1}, 32'h0);
    rsta = 1'b0;

    // Clear to a known all-zero state.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(17);

    // Byte lanes
    wr_a(5, 32'h11223344, 4'b1111);
    wr_a(5, 32'hAABBCCDD, 4'b0101);
    rd_ab(5, 5);
    idle(2);

    // Read during write on port A (old word is zero).
    wr_a(7, 32'hDEADBEEF, 4'b1111);
    rd_ab(7, 7);
    idle(2);

    // Same-address collision, then cross-port read of a word A is writing.
    step(1, 3, 32'h000000AA, 4'b0001, 1, 3, 32'hBBBBBBBB, 4'b1111, 0);
    rd_ab(3, 3);
    step(1, 3, 32'h12345678, 4'b1111, 1, 3, 0, 0, 0);
    rd_ab(3, 3);
    // Port B partial write while port A reads the same word.
    step(1, 9, 0, 0, 1, 9, 32'hCAFEF00D, 4'b1100, 0);
    rd_ab(9, 9);
    idle(2);

    // Enable hold and output latency on port B.
    step(0, 0, 0, 0, 1, 5, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 7, 0, 0, 0);
    check("hold_b0_1", doutb0, 32'h11BB33DD);
    check("hold_b1_1", doutb1, 32'h11BB33DD);
    step(0, 0, 0, 0, 0, 3, 0, 0, 0);
    check("hold_b0_2", doutb0, 32'h11BB33DD);
    check("hold_b1_2", doutb1, 32'h11BB33DD);
    step(0, 0, 0, 0, 0, 9, 0, 0, 0);
    check("hold_b0_3", doutb0, 32'h11BB33DD);
    check("hold_b1_3", doutb1, 32'h11BB33DD);
    step(0, 0, 0, 0, 1, 7, 0, 0, 0);
    check("lat_b0_1cyc", doutb0, 32'hDEADBEEF);
    check("lat_b1_1cyc", doutb1, 32'h11BB33DD);
    idle(1);
    check("lat_b1_2cyc", doutb1, 32'hDEADBEEF);
    idle(1);

    // Full clear after a preload of all ones.
    for (int i = 0; i < DEPTH / 2; i++)
      step(1, AW'(2 * i), 32'hFFFFFFFF, 4'b1111, 1, AW'(2 * i + 1), 32'hFFFFFFFF, 4'b1111, 0);
    idle(2);
    step(1, 5, 0, 0, 0, 0, 0, 0, 1);  // read completes, clear starts next edge
    step(1, 2, 32'h55555555, 4'b1111, 1, 9, 32'h66666666, 4'b1111, 0);
    step(1, 0, 0, 0, 1, 1, 0, 0, 1);  // clr while busy: ignored
    check("busy_hold_a0", douta0, 32'hFFFFFFFF);
    check("busy_hold_a1", douta1, 32'hFFFFFFFF);
    step(0, 0, 0, 0, 1, 2, 32'h77777777, 4'b0011, 0);
    step(1, 4, 32'h12121212, 4'b1111, 0, 0, 0, 0, 0);
    idle(12);
    idle(1);
    for (int i = 0; i < DEPTH; i++) rd_ab(AW'(i), AW'(DEPTH - 1 - i));
    idle(2);

    // Reset in the middle of a clear.
    for (int i = 0; i < DEPTH / 2; i++)
      step(1, AW'(2 * i), 32'hFFFFFFFF, 4'b1111, 1, AW'(2 * i + 1), 32'hFFFFFFFF, 4'b1111, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(6);
    rsta = 1'b1;
    #1;
    m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    check("abort_busy0", {31'b0, busy0}, 32'h0);
    check("abort_busy1", {31'b0, busy1}, 32'h0);
    check("abort_douta0", douta0, 32'h0);
    check("abort_doutb1", doutb1, 32'h0);
    @(posedge clk);
    edge_n++;
    #1;
    check("abort_done0", {31'b0, done0}, 32'h0);
    check("abort_done1", {31'b0, done1}, 32'h0);
    rsta = 1'b0;
    idle(1);
    for (int i = 0; i < DEPTH; i++) rd_ab(AW'(i), AW'(DEPTH - 1 - i));
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
